// File: rtl/systolic_feeder_if.sv
// Handshake and array-drive bundle between the unified buffer, the feeder and the 2x2 systolic array.
// master = buffer side (drives tiles/rows), slave = feeder side (drives ready and sys_* signals).
interface systolic_feeder_if #(
  parameter int unsigned DATA_W = 16
);
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_00;
  logic [DATA_W-1:0] w_01;
  logic [DATA_W-1:0] w_10;
  logic [DATA_W-1:0] w_11;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data_0;
  logic [DATA_W-1:0] in_data_1;
  logic              in_last;
  logic              sys_accept_w_in;
  logic [DATA_W-1:0] sys_weight_in_11;
  logic [DATA_W-1:0] sys_weight_in_12;
  logic              sys_switch_in;
  logic              sys_start;
  logic [DATA_W-1:0] sys_data_in_11;
  logic [DATA_W-1:0] sys_data_in_21;
  logic              feed_done;

  modport master (
    output w_valid, w_00, w_01, w_10, w_11, in_valid, in_data_0, in_data_1, in_last,
    input  w_ready, in_ready, sys_accept_w_in, sys_weight_in_11, sys_weight_in_12,
           sys_switch_in, sys_start, sys_data_in_11, sys_data_in_21, feed_done
  );

  modport slave (
    input  w_valid, w_00, w_01, w_10, w_11, in_valid, in_data_0, in_data_1, in_last,
    output w_ready, in_ready, sys_accept_w_in, sys_weight_in_11, sys_weight_in_12,
           sys_switch_in, sys_start, sys_data_in_11, sys_data_in_21, feed_done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Feeds a 2x2 weight tile and a skewed row stream into the systolic array; sys_* outputs registered.
// Optional FEEDER_STALL_CNT_EN adds stall_cnt, counting STREAM cycles with no input row offered.
module systolic_feeder #(
  parameter int unsigned DATA_W = 16
`ifdef FEEDER_STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  systolic_feeder_if.slave bus
`ifdef FEEDER_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLw0    = 3'd1;
  localparam logic [2:0] StLw1    = 3'd2;
  localparam logic [2:0] StLw2    = 3'd3;
  localparam logic [2:0] StStream = 3'd4;
  localparam logic [2:0] StDrain  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] w00_q, w01_q, w11_q;
  logic              first_q;
  logic [DATA_W-1:0] d1_q;
  logic              accept_q, switch_q, start_q, done_q;
  logic [DATA_W-1:0] wt11_q, wt12_q, data11_q, data21_q;
  logic              w_fire, row_fire;

  assign w_fire   = bus.w_valid && (state_q == StIdle);
  assign row_fire = bus.in_valid && (state_q == StStream);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (w_fire) state_d = StLw0;
      StLw0:    state_d = StLw1;
      StLw1:    state_d = StLw2;
      StLw2:    state_d = StStream;
      StStream: if (row_fire && bus.in_last) state_d = StDrain;
      // First DRAIN cycle raises feed_done; the second (done visible) returns to IDLE.
      StDrain:  if (done_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      w00_q    <= '0;
      w01_q    <= '0;
      w11_q    <= '0;
      first_q  <= 1'b0;
      d1_q     <= '0;
      accept_q <= 1'b0;
      wt11_q   <= '0;
      wt12_q   <= '0;
      switch_q <= 1'b0;
      start_q  <= 1'b0;
      data11_q <= '0;
      data21_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_fire) begin
        w00_q <= bus.w_00;
        w01_q <= bus.w_01;
        w11_q <= bus.w_11;
      end
      // w_10 leaves on the capture edge itself, so it is taken straight from the bus.
      accept_q <= (state_d == StLw0) || (state_d == StLw1);
      wt11_q   <= (state_d == StLw0) ? bus.w_10 : (state_d == StLw1) ? w00_q : '0;
      wt12_q   <= (state_d == StLw1) ? w11_q : (state_d == StLw2) ? w01_q : '0;
      if (state_q == StLw2) begin
        first_q <= 1'b1;
      end else if (row_fire) begin
        first_q <= 1'b0;
      end
      switch_q <= row_fire && first_q;
      start_q  <= row_fire;
      data11_q <= row_fire ? bus.in_data_0 : '0;
      d1_q     <= row_fire ? bus.in_data_1 : '0;
      data21_q <= d1_q;
      done_q   <= (state_q == StDrain) && !done_q;
    end
  end

  assign bus.w_ready          = (state_q == StIdle);
  assign bus.in_ready         = (state_q == StStream);
  assign bus.sys_accept_w_in  = accept_q;
  assign bus.sys_weight_in_11 = wt11_q;
  assign bus.sys_weight_in_12 = wt12_q;
  assign bus.sys_switch_in    = switch_q;
  assign bus.sys_start        = start_q;
  assign bus.sys_data_in_11   = data11_q;
  assign bus.sys_data_in_21   = data21_q;
  assign bus.feed_done        = done_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || w_fire) begin
      stall_q <= '0;
    end else if ((state_q == StStream) && !bus.in_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: directed tiles/rows push expected array beats into a queue,
// a negedge monitor pops one per cycle in which any sys_* output or feed_done is non-zero.
module tb_systolic_feeder;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          acc;
    logic [DW-1:0] w11;
    logic [DW-1:0] w12;
    logic          sw;
    logic          st;
    logic [DW-1:0] d11;
    logic [DW-1:0] d21;
    logic          done;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];

  systolic_feeder_if #(.DATA_W(DW)) ifc ();

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
  systolic_feeder #(.DATA_W(DW), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc),
                                                  .stall_cnt(stall_cnt));
`else
  systolic_feeder #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(ifc));
`endif

  always #5 clk = ~clk;

  function automatic beat_t mk(logic acc, int w11, int w12, logic sw, logic st, int d11, int d21,
                               logic done);
    beat_t b;
    b.acc = acc; b.w11 = DW'(w11); b.w12 = DW'(w12); b.sw = sw; b.st = st;
    b.d11 = DW'(d11); b.d21 = DW'(d21); b.done = done;
    return b;
  endfunction

  function automatic beat_t cur();
    return mk(ifc.sys_accept_w_in, int'(ifc.sys_weight_in_11), int'(ifc.sys_weight_in_12),
              ifc.sys_switch_in, ifc.sys_start, int'(ifc.sys_data_in_11),
              int'(ifc.sys_data_in_21), ifc.feed_done);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: each active beat must match the oldest queued expectation.
  always @(negedge clk) begin
    beat_t b, e;
    if (mon_en) begin
      b = cur();
      if (b != '0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no activity", b);
        end else begin
          e = exp_q.pop_front();
          if (b !== e) begin
            n_fail++;
            $display("FAIL beat: got %h, expected %h", b, e);
          end
        end
      end
    end
  end

  task automatic wait_ready(input bit is_w);
    int k = 0;
    while (((is_w ? ifc.w_ready : ifc.in_ready) !== 1'b1) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if ((is_w ? ifc.w_ready : ifc.in_ready) !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: got 0, expected %s high within 50 cycles",
               is_w ? "w_ready" : "in_ready");
    end
  endtask

  // Weight tile plus the three load beats it must produce.
  task automatic load_w(input int a00, input int a01, input int a10, input int a11);
    exp_q.push_back(mk(1, a10, 0,   0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, a00, a11, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0,   a01, 0, 0, 0, 0, 0));
    ifc.w_valid = 1'b1;
    ifc.w_00 = DW'(a00); ifc.w_01 = DW'(a01); ifc.w_10 = DW'(a10); ifc.w_11 = DW'(a11);
    wait_ready(1'b1);
    @(posedge clk); #1;
    ifc.w_valid = 1'b0;
  endtask

  task automatic send_row(input int d0, input int d1, input logic last);
    ifc.in_valid = 1'b1;
    ifc.in_data_0 = DW'(d0); ifc.in_data_1 = DW'(d1); ifc.in_last = last;
    wait_ready(1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    ifc.w_valid = 1'b0; ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
    ifc.w_00 = '0; ifc.w_01 = '0; ifc.w_10 = '0; ifc.w_11 = '0;
    ifc.in_data_0 = '0; ifc.in_data_1 = '0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'(cur()), 32'(0));
    check("rst_in_ready", 32'(ifc.in_ready), 32'(0));
    check("rst_feed_done", 32'(ifc.feed_done), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("w_ready_after_rst", 32'(ifc.w_ready), 32'(1));
    @(posedge clk); #1;

    // Load 1,2,3,4 then back-to-back rows (5,6),(7,8,last).
    load_w(1, 2, 3, 4);
    exp_q.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 1, 7, 6, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8, 1));
    send_row(5, 6, 1'b0);
    send_row(7, 8, 1'b1);
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
    @(negedge clk);
    check("drain_in_ready", 32'(ifc.in_ready), 32'(0));
    @(negedge clk);
    check("done_cycle_w_ready", 32'(ifc.w_ready), 32'(0));
    check("done_cycle_feed_done", 32'(ifc.feed_done), 32'(1));
    @(negedge clk);
    check("idle_after_done", 32'(ifc.w_ready), 32'(1));
    @(posedge clk); #1;

    // Load 9,10,11,12 then (5,6), one-cycle gap, (7,8,last).
    load_w(9, 10, 11, 12);
    exp_q.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8, 1));
    send_row(5, 6, 1'b0);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("gap_in_ready", 32'(ifc.in_ready), 32'(1));
    ifc.w_valid = 1'b1;  // must be ignored outside IDLE
    @(posedge clk); #1;
    ifc.w_valid = 1'b0;
    send_row(7, 8, 1'b1);
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
    wait_ready(1'b1);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cnt_gap", 32'(stall_cnt), 32'(1));
`endif

    // Mid-batch reset: row (5,6) accepted, rst one cycle later, no feed_done afterwards.
    load_w(1, 2, 3, 4);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cnt_cleared", 32'(stall_cnt), 32'(0));
`endif
    exp_q.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0));
    send_row(5, 6, 1'b0);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_data21", 32'(ifc.sys_data_in_21), 32'(0));
    check("mid_rst_outputs", 32'(cur()), 32'(0));
    check("mid_rst_w_ready", 32'(ifc.w_ready), 32'(1));
    check("mid_rst_in_ready", 32'(ifc.in_ready), 32'(0));
    repeat (4) @(posedge clk);
    #1;

    // Single-row batch: switch, start and done all appear.
    load_w(21, 22, 23, 24);
    exp_q.push_back(mk(0, 0, 0, 1, 1, 9, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 10, 1));
    send_row(9, 10, 1'b1);
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
    wait_ready(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
